// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types and constants for the change dispenser
package vending_pkg;

    localparam int AMT_W = 8;

    typedef enum logic [1:0] {
        C1  = 2'd0,
        C5  = 2'd1,
        C10 = 2'd2,
        C50 = 2'd3
    } coin_e;

    // Face value of each coin, indexed by coin_e encoding
    localparam logic [7:0] COIN_VAL [4] = '{8'd1, 8'd5, 8'd10, 8'd50};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_ISSUE  = 2'd2,
        S_DONE   = 2'd3
    } disp_state_e;

endpackage

// File: rtl/coin_pick.sv
// rtl/coin_pick.sv - greedy picker for the largest in-stock coin that fits
module coin_pick #(
    parameter int AMT_W = vending_pkg::AMT_W
) (
    input  logic [AMT_W-1:0] remain,
    input  logic [3:0]       avail,
    output logic             found,
    output logic [1:0]       coin_sel
);
    import vending_pkg::*;

    // Ascending scan so the last hit is the largest qualifying denomination
    always_comb begin
        found    = 1'b0;
        coin_sel = C1;
        for (int i = 0; i < 4; i++) begin
            if (avail[i] && (remain >= AMT_W'(COIN_VAL[i]))) begin
                found    = 1'b1;
                coin_sel = 2'(i);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out change one coin per hopper handshake
module change_dispenser #(
    parameter logic [7:0] STOCK_INIT = 8'd10,
    parameter int          AMT_W     = vending_pkg::AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chg_valid,
    input  logic [AMT_W-1:0] chg_amt,
    output logic             chg_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    input  logic             coin_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] short_amt,
    input  logic             refill,
    input  logic [1:0]       refill_sel,
    input  logic [7:0]       refill_cnt,
    output logic             busy
);
    import vending_pkg::*;

    disp_state_e      state;
    disp_state_e      state_next;
    logic [AMT_W-1:0] remain;
    logic [7:0]       stock [4];
    logic [3:0]       avail;
    logic             pick_found;
    logic [1:0]       pick_sel;
    logic [AMT_W-1:0] coin_val;
    logic             accept;

    assign accept   = chg_valid && chg_ready;
    assign busy     = (state != S_IDLE);
    assign coin_val = AMT_W'(COIN_VAL[coin_sel]);

    // Availability flags feed the picker; an empty tube is never chosen
    always_comb begin
        avail = '0;
        for (int i = 0; i < 4; i++) begin
            avail[i] = (stock[i] != 8'd0);
        end
    end

    coin_pick #(
        .AMT_W (AMT_W)
    ) u_coin_pick (
        .remain   (remain),
        .avail    (avail),
        .found    (pick_found),
        .coin_sel (pick_sel)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_SELECT;
                end
            end
            S_SELECT: begin
                if ((remain != '0) && pick_found) begin
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_ISSUE: begin
                if (coin_ack) begin
                    state_next = S_SELECT;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Remainder tracking and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remain     <= '0;
            chg_ready  <= 1'b0;
            coin_valid <= 1'b0;
            coin_sel   <= 2'd0;
            done       <= 1'b0;
            short      <= 1'b0;
            short_amt  <= '0;
        end else begin
            chg_ready <= (state_next == S_IDLE);
            done      <= 1'b0;
            short     <= 1'b0;
            short_amt <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        remain <= chg_amt;
                    end
                end
                S_SELECT: begin
                    if (state_next == S_ISSUE) begin
                        coin_valid <= 1'b1;
                        coin_sel   <= pick_sel;
                    end else begin
                        // Any leftover here is unpayable with the current stock
                        done      <= 1'b1;
                        short     <= (remain != '0);
                        short_amt <= remain;
                    end
                end
                S_ISSUE: begin
                    if (coin_ack) begin
                        coin_valid <= 1'b0;
                        coin_sel   <= 2'd0;
                        remain     <= remain - coin_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Inventory: saturating refill while idle, one coin debited per handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                stock[i] <= STOCK_INIT;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if ((state == S_IDLE) && refill && (refill_sel == 2'(i))) begin
                    if (({1'b0, stock[i]} + {1'b0, refill_cnt}) > 9'd255) begin
                        stock[i] <= 8'd255;
                    end else begin
                        stock[i] <= stock[i] + refill_cnt;
                    end
                end else if ((state == S_ISSUE) && coin_ack && (coin_sel == 2'(i))) begin
                    stock[i] <= stock[i] - 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending machine: takes the change amount produced on `MO` at the end of a purchase and pays it out one coin per handshake to the coin hopper. It uses denominations 50/10/5/1, picks the largest coin that fits and is in stock (greedy), and tracks a per-denomination inventory. It reports any unpayable remainder and accepts hopper refills while idle.

## Interface
Parameters:
- `STOCK_INIT`, 8'd10, coins of each denomination after reset
- `AMT_W`, 8, width of change amount (matches `MO`)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset)
- `chg_valid` in 1: change request valid
- `chg_amt` in AMT_W: change to pay, unsigned, sampled on accept
- `chg_ready` out 1: block idle, can accept a request
- `coin_valid` out 1: a coin is being issued
- `coin_sel` out 2: 0 = 1, 1 = 5, 2 = 10, 3 = 50
- `coin_ack` in 1: hopper took the coin
- `done` out 1: one-cycle pulse, request finished
- `short` out 1: valid with `done`; remainder could not be paid
- `short_amt` out AMT_W: unpaid remainder, valid with `done`, else 0
- `refill` in 1: add coins (honoured only in IDLE)
- `refill_sel` in 2: denomination to refill
- `refill_cnt` in 8: number of coins added; stock saturates at 255
- `busy` out 1: state != IDLE

## Operation
- States: IDLE, SELECT, ISSUE, DONE.
- **IDLE:** `chg_ready`=1. On `chg_valid`, latch `chg_amt` into `remain` and go to SELECT. When `refill`=1 in the same cycle, the refill is applied and the request is still accepted.
- **SELECT:**
  - If `remain`==0, go to DONE with `short`=0.
  - Otherwise pick the largest d in {50,10,5,1} with d ≤ `remain` and stock[d] > 0, register `coin_sel`, and go to ISSUE.
  - If no such d exists, go to DONE with `short`=1 and `short_amt`=`remain`.
- **ISSUE:** `coin_valid`=1 and `coin_sel` is held stable until `coin_ack`. On `coin_ack`: `remain` -= d, stock[d] -= 1, go to SELECT. `coin_ack` outside ISSUE is ignored.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- Greedy without backtracking is the decided policy. Example: 8 with no 5s and only three 1s pays three 1s and ends short 5.
- `chg_amt`=0: SELECT→DONE with no coins and `short`=0.
- `refill` outside IDLE is dropped (no queuing).
- All arithmetic is unsigned AMT_W. `remain` never underflows because d ≤ `remain` is guaranteed.

## Timing
- Reset values: `chg_ready`=0 while `rst`=0, then 1 in IDLE. All other outputs are 0. Stock = `STOCK_INIT`, `remain`=0.
- Reset mid-operation aborts immediately (asynchronous): `coin_valid` drops, no `done` is issued, and stock reloads `STOCK_INIT` (issued coins are not re-credited).
- The accept edge is cycle 0; SELECT is cycle 1.
- With zero-wait `coin_ack` (ack in the first ISSUE cycle), N coins take 2 cycles each. `done` is high in cycle 2N+2.
- Each cycle of ack delay adds one cycle.
- `chg_ready` returns to 1 in the cycle after `done`; a back-to-back request can be accepted then.
- `coin_valid` and `coin_sel` are registered outputs; `done`, `short`, and `short_amt` are registered.

## Structure
- `vending_pkg` holds:
  - the `coin_e` enum (C1, C5, C10, C50)
  - a localparam array of denomination values
  - the `disp_state_e` enum
  - `AMT_W`
- Sub-module `coin_pick`: combinational priority picker. Inputs are `remain` and four "stock>0" flags; outputs are `found` and `coin_sel`. All other logic stays in `change_dispenser`.

## Test plan
- Reset, stock 10 each, request 66, ack every cycle → coins 50,10,5,1; `done` in cycle 10; `short`=0; stock 9/9/9/9.
- Request 0 → no `coin_valid`; `done` in cycle 2; `short`=0; `chg_ready` back in cycle 3.
- Stock[5]=0, stock[1]=3, request 8 → three 1-coins, then `done` with `short`=1, `short_amt`=5.
- Request 15 with `coin_ack` delayed 3 cycles per coin → `coin_sel` stable during each wait; `done` in cycle 12.
- `refill` sel=3 cnt=250 from stock 10 in IDLE → stock 255 (saturated); the same refill during ISSUE → stock unchanged.
- Assert `rst`=0 during ISSUE of request 60 → `coin_valid` drops immediately; no `done`; stock = 10 after release.
